// File: rtl/tlv320_i2c_target.sv
// I2C target for TLV320/WM8731 control writes ({reg_addr[6:0], reg_data[8:0]}) feeding a 9-bit shadow register file.
// Define TLV320_I2C_READBACK_EN to enable read-back of the last written register.
module tlv320_i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic                  inclk_i2c,
  input  logic                  reset,
  input  logic                  i2c_scl,
  input  logic                  i2c_sda_in,
  output logic                  i2c_sda_oe,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [8:0]            wr_data,
  output logic [NUM_REGS*9-1:0] reg_file,
  output logic                  busy
);
  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0]  SOFT_RST_ADDR = 7'h0F;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE0, S_ACK0, S_BYTE1, S_ACK1, S_WAIT_STOP, S_IGNORE
`ifdef TLV320_I2C_READBACK_EN
    , S_RD_ADDR_ACK, S_RD_BYTE, S_RD_CACK
`endif
  } state_t;

  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-2:0] scl_hist, sda_hist;
  logic [FILT_LEN-1:0] scl_win, sda_win;
  logic                scl_f, sda_f, scl_q, sda_q;
  logic                scl_rise, scl_fall, start_det, stop_det;

  state_t      state, state_n;
  logic [3:0]  bit_cnt;
  logic        byte_done;
  logic [7:0]  shreg, byte0;
  logic        commit, oe_n, busy_n;
  logic [6:0]  cw_addr;
  logic [8:0]  cw_data;
  logic        cw_in_range;
  logic [8:0]  regs [NUM_REGS];

  assign scl_win = {scl_hist, scl_sync[1]};
  assign sda_win = {sda_hist, sda_sync[1]};

  // Input conditioning is not reset, so filtered levels keep tracking the bus across a reset.
  always_ff @(posedge inclk_i2c) begin
    scl_sync <= {scl_sync[0], i2c_scl};
    sda_sync <= {sda_sync[0], i2c_sda_in};
    scl_hist <= scl_win[FILT_LEN-2:0];
    sda_hist <= sda_win[FILT_LEN-2:0];
    if (&scl_win)       scl_f <= 1'b1;
    else if (~|scl_win) scl_f <= 1'b0;
    if (&sda_win)       sda_f <= 1'b1;
    else if (~|sda_win) sda_f <= 1'b0;
    scl_q <= scl_f;
    sda_q <= sda_f;
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & ~sda_f & sda_q;
  assign stop_det  = scl_f & scl_q & sda_f & ~sda_q;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);

  assign cw_addr     = byte0[7:1];
  assign cw_data     = {byte0[0], shreg};
  assign cw_in_range = (32'(cw_addr) < NUM_REGS);

`ifdef TLV320_I2C_READBACK_EN
  logic [15:0] tx, tx_n, rd_word;
  logic        rd_second, cack;

  assign rd_word = {wr_addr, (32'(wr_addr) < NUM_REGS) ? regs[wr_addr[AW-1:0]] : 9'h000};

  always_ff @(posedge inclk_i2c) begin
    if (reset) begin
      tx        <= '0;
      rd_second <= 1'b0;
      cack      <= 1'b0;
    end else begin
      tx <= tx_n;
      if (state_n == S_RD_ADDR_ACK)
        rd_second <= 1'b0;
      else if (state == S_RD_CACK && state_n == S_RD_BYTE)
        rd_second <= 1'b1;
      if (scl_rise && state == S_RD_CACK)
        cack <= ~sda_f;
    end
  end
`endif

  always_comb begin
    state_n = state;
    commit  = 1'b0;
`ifdef TLV320_I2C_READBACK_EN
    tx_n    = tx;
`endif
    case (state)
      S_ADDR: begin
        if (byte_done) begin
          if (shreg == {DEV_ADDR, 1'b0})      state_n = S_ADDR_ACK;
`ifdef TLV320_I2C_READBACK_EN
          else if (shreg == {DEV_ADDR, 1'b1}) state_n = S_RD_ADDR_ACK;
`endif
          else                                state_n = S_IGNORE;
        end
      end
      S_ADDR_ACK: if (scl_fall)  state_n = S_BYTE0;
      S_BYTE0:    if (byte_done) state_n = S_ACK0;
      S_ACK0:     if (scl_fall)  state_n = S_BYTE1;
      S_BYTE1:    if (byte_done) state_n = S_ACK1;
      S_ACK1: begin
        if (scl_fall) begin
          state_n = S_WAIT_STOP;
          commit  = 1'b1;
        end
      end
`ifdef TLV320_I2C_READBACK_EN
      S_RD_ADDR_ACK: begin
        if (scl_fall) begin
          state_n = S_RD_BYTE;
          tx_n    = rd_word;
        end
      end
      // Shift on every fall; the 8th fall leaves byte 1's MSB at tx[15] for the next byte.
      S_RD_BYTE: begin
        if (scl_fall) begin
          tx_n = {tx[14:0], 1'b0};
          if (bit_cnt == 4'd8) state_n = S_RD_CACK;
        end
      end
      S_RD_CACK: if (scl_fall) state_n = (cack && !rd_second) ? S_RD_BYTE : S_WAIT_STOP;
`endif
      default: ;
    endcase
    if (start_det)     state_n = S_ADDR;
    else if (stop_det) state_n = S_IDLE;
  end

  always_comb begin
    oe_n   = 1'b0;
    busy_n = 1'b1;
    case (state_n)
      S_ADDR_ACK, S_ACK0, S_ACK1: oe_n = 1'b1;
`ifdef TLV320_I2C_READBACK_EN
      S_RD_ADDR_ACK:              oe_n = 1'b1;
      S_RD_BYTE:                  oe_n = ~tx_n[15];
`endif
      default: ;
    endcase
    case (state_n)
      S_IDLE, S_IGNORE: busy_n = 1'b0;
      S_ADDR:           busy_n = busy;
      default: ;
    endcase
  end

  always_ff @(posedge inclk_i2c) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte0      <= '0;
      i2c_sda_oe <= 1'b0;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state      <= state_n;
      i2c_sda_oe <= oe_n;
      busy       <= busy_n;
      wr_strobe  <= commit;
      if (start_det || state_n != state)
        bit_cnt <= '0;
      else if (scl_rise && bit_cnt != 4'd8)
        bit_cnt <= bit_cnt + 4'd1;
      if (scl_rise && (state == S_ADDR || state == S_BYTE0 || state == S_BYTE1))
        shreg <= {shreg[6:0], sda_f};
      if (state == S_BYTE0 && state_n == S_ACK0)
        byte0 <= shreg;
      if (commit) begin
        wr_addr <= cw_addr;
        wr_data <= cw_data;
        if (cw_addr == SOFT_RST_ADDR && cw_data == 9'h000)
          for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (cw_in_range)
          regs[cw_addr[AW-1:0]] <= cw_data;
      end
    end
  end

  always_comb begin
    reg_file = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_file[9*i +: 9] = regs[i];
  end

endmodule

// File: tb/tb_tlv320_i2c_target.sv
// Bench for tlv320_i2c_target: bit-banged I2C controller with an open-drain SDA model,
// directed and random frames checked against a behavioural register-file model.
module tb_tlv320_i2c_target;
  localparam int         Q    = 8;
  localparam int         NREG = 16;
  localparam logic [6:0] DEV  = 7'h1A;

  logic              clk = 1'b0;
  logic              reset, scl_drv, sda_drv, sda_line;
  logic              i2c_sda_oe, wr_strobe, busy;
  logic [6:0]        wr_addr;
  logic [8:0]        wr_data;
  logic [NREG*9-1:0] reg_file;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  logic [8:0] mregs [NREG];
  logic [6:0] m_addr;
  logic [8:0] m_data;

  always #5 clk = ~clk;
  assign sda_line = sda_drv & ~i2c_sda_oe;

  tlv320_i2c_target #(.DEV_ADDR(DEV), .NUM_REGS(NREG), .FILT_LEN(3)) dut (
    .inclk_i2c (clk),
    .reset     (reset),
    .i2c_scl   (scl_drv),
    .i2c_sda_in(sda_line),
    .i2c_sda_oe(i2c_sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .reg_file  (reg_file),
    .busy      (busy)
  );

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: observed no finish, required finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) mregs[i] = 9'h000;
    m_addr = 7'h00;
    m_data = 9'h000;
  endtask

  task automatic model_write(input logic [6:0] ra, input logic [8:0] rd);
    m_addr = ra;
    m_data = rd;
    if (ra == 7'h0F && rd == 9'h000) begin
      for (int i = 0; i < NREG; i++) mregs[i] = 9'h000;
    end else if (int'(ra) < NREG) begin
      mregs[int'(ra)] = rd;
    end
  endtask

  function automatic logic [NREG*9-1:0] model_flat();
    logic [NREG*9-1:0] f;
    for (int i = 0; i < NREG; i++) f[9*i +: 9] = mregs[i];
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q);
    sda_drv = 1'b0; tick(Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(Q);
    scl_drv = 1'b1; tick(Q);
    sda_drv = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;    tick(Q);
    scl_drv = 1'b1; tick(2*Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q);
    b = sda_line;   tick(Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit glitch, output bit ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (glitch && i == 4) begin
        scl_drv = 1'b1; tick(1);
        scl_drv = 1'b0; tick(Q);
      end
    end
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] v, input bit ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic do_write(input logic [6:0] ra, input logic [8:0] rd, input bit glitch, input string tag);
    bit a0, a1, a2;
    int s0;
    s0 = strobe_cnt;
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a0);
    check({tag, "_busy_in"}, busy, 1'b1);
    send_byte({ra, rd[8]}, 1'b0, a1);
    send_byte(rd[7:0], glitch, a2);
    bus_stop();
    model_write(ra, rd);
    check({tag, "_acks"}, {a0, a1, a2}, 3'b111);
    check({tag, "_strobes"}, 144'(strobe_cnt - s0), 144'd1);
    check({tag, "_wr_addr"}, wr_addr, m_addr);
    check({tag, "_wr_data"}, wr_data, m_data);
    check({tag, "_regs"}, reg_file, model_flat());
    check({tag, "_busy_out"}, busy, 1'b0);
  endtask

  initial begin
    bit a0, a1, a2, a3;
    int s0;
    logic [7:0] v0, v1, mb;
    logic [6:0] ra, ma;
    logic [8:0] rd;

    reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    model_clear();
    tick(1);
    check("rst_oe", i2c_sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_regs", reg_file, '0);
    check("rst_strobe", wr_strobe, 1'b0);
    tick(8);
    reset = 1'b0;
    tick(8);

    do_write(7'h04, 9'h014, 1'b0, "t2");
    check("t2_reg4", reg_file[4*9 +: 9], 9'h014);

    s0 = strobe_cnt;
    bus_start();
    send_byte({DEV, 1'b1}, 1'b0, a0);
`ifdef TLV320_I2C_READBACK_EN
    check("rd_addr_ack", a0, 1'b1);
    recv_byte(v0, 1'b1);
    recv_byte(v1, 1'b0);
    bus_stop();
    rd = (int'(m_addr) < NREG) ? mregs[int'(m_addr)] : 9'h000;
    check("rd_byte0", v0, {m_addr, rd[8]});
    check("rd_byte1", v1, rd[7:0]);
`else
    check("rd_addr_nack", a0, 1'b0);
    check("rd_busy", busy, 1'b0);
    bus_stop();
`endif
    check("rd_strobes", 144'(strobe_cnt - s0), 144'd0);
    check("rd_oe_idle", i2c_sda_oe, 1'b0);

    s0 = strobe_cnt;
    bus_start();
    send_byte(8'h36, 1'b0, a0);
    check("t3_busy", busy, 1'b0);
    send_byte(8'h08, 1'b0, a1);
    send_byte(8'h14, 1'b0, a2);
    bus_stop();
    check("t3_acks", {a0, a1, a2}, 3'b000);
    check("t3_strobes", 144'(strobe_cnt - s0), 144'd0);
    check("t3_regs", reg_file, model_flat());

    s0 = strobe_cnt;
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a0);
    send_byte(8'h0A, 1'b0, a1);
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a2);
    send_byte(8'h0E, 1'b0, a3);
    send_byte(8'h02, 1'b0, a1);
    bus_stop();
    model_write(7'h07, 9'h002);
    check("t4_acks", {a0, a2, a3, a1}, 4'b1111);
    check("t4_strobes", 144'(strobe_cnt - s0), 144'd1);
    check("t4_regs", reg_file, model_flat());

    do_write(7'h0F, 9'h000, 1'b0, "t5_soft");
    check("t5_all_zero", reg_file, '0);
    do_write(7'h09, 9'h1A5, 1'b1, "t5_glitch");

    s0 = strobe_cnt;
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a0);
    send_byte({7'h03, 1'b1}, 1'b0, a1);
    send_byte(8'h3C, 1'b0, a2);
    send_byte(8'hFF, 1'b0, a3);
    bus_stop();
    model_write(7'h03, 9'h13C);
    check("extra_acks", {a0, a1, a2, a3}, 4'b1110);
    check("extra_strobes", 144'(strobe_cnt - s0), 144'd1);
    check("extra_regs", reg_file, model_flat());

    s0 = strobe_cnt;
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a0);
    send_byte(8'h10, 1'b0, a1);
    bus_stop();
    check("stopmid_strobes", 144'(strobe_cnt - s0), 144'd0);
    check("stopmid_busy", busy, 1'b0);
    check("stopmid_regs", reg_file, model_flat());

    for (int n = 0; n < 16; n++) begin
      ra = 7'($urandom_range(0, 20));
      rd = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) begin
        ra = 7'h0F;
        rd = 9'h000;
      end
      do_write(ra, rd, 1'b0, "rand_wr");
      if (n % 3 == 0) begin
        ma = 7'($urandom_range(0, 127));
        if (ma == DEV) ma = DEV ^ 7'h01;
        mb = {ma, 1'b0};
        s0 = strobe_cnt;
        bus_start();
        send_byte(mb, 1'b0, a0);
        send_byte(8'($urandom), 1'b0, a1);
        send_byte(8'($urandom), 1'b0, a2);
        bus_stop();
        check("rand_miss_acks", {a0, a1, a2}, 3'b000);
        check("rand_miss_strobes", 144'(strobe_cnt - s0), 144'd0);
        check("rand_miss_regs", reg_file, model_flat());
      end
    end

    bus_start();
    for (int i = 7; i >= 1; i--) send_bit(DEV[i-1]);
    send_bit(1'b0);
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q);
    check("mid_oe_before", i2c_sda_oe, 1'b1);
    check("mid_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick(1);
    model_clear();
    check("mid_oe_after", i2c_sda_oe, 1'b0);
    check("mid_busy_after", busy, 1'b0);
    check("mid_regs_after", reg_file, model_flat());
    reset = 1'b0;
    tick(Q);
    scl_drv = 1'b0; tick(Q);
    s0 = strobe_cnt;
    send_byte(8'h08, 1'b0, a1);
    send_byte(8'h55, 1'b0, a2);
    bus_stop();
    check("mid_ignore_acks", {a1, a2}, 2'b00);
    check("mid_ignore_strobes", 144'(strobe_cnt - s0), 144'd0);
    do_write(7'h02, 9'h0C3, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
